// File: rtl/bnn_seq_classifier.sv
// Time-multiplexed binary neural network classifier: one neuron per cycle,
// runtime-loadable weights/biases, incremental argmax over output scores.
module bnn_seq_classifier #(
    parameter int N_IN  = 8,
    parameter int N_HID = 8,
    parameter int N_OUT = 2,
    parameter int BW    = 6,
    parameter int SCW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_IN-1:0]          x_in,
    input  logic                     cfg_we,
    input  logic [1:0]               cfg_sel,
    input  logic [3:0]               cfg_addr,
    input  logic [15:0]              cfg_data,
    output logic                     cfg_rej,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(N_OUT)-1:0] class_out,
    output logic [N_OUT*SCW-1:0]     scores,
    output logic [N_HID-1:0]         hidden_out
);

    localparam int IW = $clog2(N_HID);
    localparam int OW = $clog2(N_OUT);
    localparam int SW = SCW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HID, S_OUT, S_DONE} state_t;

    state_t state, state_nx;

    logic [N_HID-1:0][N_IN-1:0]  wh;
    logic [N_HID-1:0][BW-1:0]    bh;
    logic [N_OUT-1:0][N_HID-1:0] wo;
    logic [N_OUT-1:0][BW-1:0]    bo;

    logic [N_IN-1:0]             x_reg;
    logic [IW-1:0]               i_cnt;
    logic [OW-1:0]               j_cnt;
    logic [N_HID-1:0]            h_work;
    logic [N_OUT-1:0][SCW-1:0]   sc_work;
    logic signed [SCW-1:0]       best_val;
    logic [OW-1:0]               best_idx;

    logic                        idle_like;
    logic                        accept;
    logic                        addr_ok;
    logic                        cfg_ok;
    logic                        cfg_bad;
    logic [N_IN-1:0]             agree_h;
    logic [N_HID-1:0]            agree_o;
    logic [SW-1:0]               pop_h;
    logic [SW-1:0]               pop_o;
    logic signed [SW-1:0]        sum_h;
    logic signed [SW-1:0]        sum_o;
    logic signed [SCW-1:0]       score_o;
    logic                        h_bit;
    logic                        unused_cfg;

    // Upper address/data bits are don't-care for narrow configurations.
    assign unused_cfg = ^{cfg_addr, cfg_data};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        idle_like = (state == S_IDLE) || (state == S_DONE);
        accept    = start && idle_like;
        state_nx  = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_HID;
            S_HID:   if (i_cnt == IW'(N_HID - 1)) state_nx = S_OUT;
            S_OUT:   if (j_cnt == OW'(N_OUT - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = start ? S_HID : S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        addr_ok = 1'b0;
        case (cfg_sel)
            2'd0, 2'd1: addr_ok = ({1'b0, cfg_addr} < 5'(N_HID));
            default:    addr_ok = ({1'b0, cfg_addr} < 5'(N_OUT));
        endcase
        cfg_ok  = cfg_we && idle_like && addr_ok;
        cfg_bad = cfg_we && !cfg_ok;
    end

    // XNOR-popcount neurons: sum = 2*pop - N + sext(bias), evaluated at SCW+1 bits.
    always_comb begin
        agree_h = ~(x_reg ^ wh[i_cnt]);
        pop_h   = SW'($countones(agree_h));
        sum_h   = signed'(pop_h + pop_h) - SW'(N_IN) + SW'(signed'(bh[i_cnt]));
        h_bit   = ~sum_h[SW-1];

        agree_o = ~(h_work ^ wo[j_cnt]);
        pop_o   = SW'($countones(agree_o));
        sum_o   = signed'(pop_o + pop_o) - SW'(N_HID) + SW'(signed'(bo[j_cnt]));
        score_o = sum_o[SCW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wh         <= '0;
            bh         <= '0;
            wo         <= '0;
            bo         <= '0;
            x_reg      <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            h_work     <= '0;
            sc_work    <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            cfg_rej    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            class_out  <= '0;
            scores     <= '0;
            hidden_out <= '0;
        end else begin
            cfg_rej <= cfg_bad;
            busy    <= (state == S_HID) || (state == S_OUT);
            done    <= (state == S_DONE);

            if (cfg_ok) begin
                case (cfg_sel)
                    2'd0: wh[cfg_addr[IW-1:0]] <= cfg_data[N_IN-1:0];
                    2'd1: bh[cfg_addr[IW-1:0]] <= cfg_data[BW-1:0];
                    2'd2: wo[cfg_addr[OW-1:0]] <= cfg_data[N_HID-1:0];
                    2'd3: bo[cfg_addr[OW-1:0]] <= cfg_data[BW-1:0];
                    default: ;
                endcase
            end

            if (accept) begin
                x_reg    <= x_in;
                i_cnt    <= '0;
                j_cnt    <= '0;
                best_val <= '0;
                best_idx <= '0;
            end else if (state == S_HID) begin
                h_work[i_cnt] <= h_bit;
                i_cnt         <= i_cnt + 1'b1;
            end else if (state == S_OUT) begin
                sc_work[j_cnt] <= score_o;
                // Strict compare keeps the lowest index on ties.
                if (j_cnt == '0 || score_o > best_val) begin
                    best_val <= score_o;
                    best_idx <= j_cnt;
                end
                j_cnt <= j_cnt + 1'b1;
            end

            // Publish results even when a back-to-back start is accepted in DONE.
            if (state == S_DONE) begin
                class_out  <= best_idx;
                scores     <= sc_work;
                hidden_out <= h_work;
            end
        end
    end

endmodule

// File: doc/bnn_seq_classifier.md
Name: bnn_seq_classifier

Overview:
Parametrised, time-multiplexed binary neural network classifier (N_IN binary inputs -> N_HID hidden -> N_OUT classes). It replaces the fixed 4-4-2 combinational BNN with runtime-loadable weights and biases, one neuron evaluated per cycle, and argmax class selection. It sits between the feature binarizer and the output/alarm logic, and is driven by a start/done handshake per frame.

Parameters:
N_IN, 8, number of binary input features (2..16)
N_HID, 8, number of hidden neurons (2..16)
N_OUT, 2, number of output classes (2..8)
BW, 6, signed bias width (two's complement)
SCW, 8, signed score width; must hold ±(max(N_IN,N_HID) + 2^(BW-1))

Ports:
clk  in  1  single system clock
rst  in  1  synchronous, active-high reset
start  in  1  request inference on x_in; accepted only in IDLE or DONE
x_in  in  N_IN  binary feature vector, latched on accepted start
cfg_we  in  1  configuration write strobe
cfg_sel  in  2  0=hidden weight row, 1=hidden bias, 2=output weight row, 3=output bias
cfg_addr  in  4  neuron index (hidden or output per cfg_sel)
cfg_data  in  16  row bits [N-1:0] (LSB-aligned), or bias [BW-1:0]
cfg_rej  out  1  one-cycle pulse: cfg write dropped (busy or addr out of range)
busy  out  1  high from the cycle after accept through the last compute cycle
done  out  1  one-cycle pulse: results updated
class_out  out  clog2(N_OUT)  argmax class index
scores  out  N_OUT*SCW  signed output scores, class k at [k*SCW +: SCW]
hidden_out  out  N_HID  hidden activation vector (debug)

Behaviour:
- Reset (rst high at clk edge): state=IDLE. busy, done, cfg_rej, class_out, scores, and hidden_out are all 0. All weight rows and biases are 0. Reset mid-run aborts the run: no done is issued and results are cleared.
- States: IDLE -> HID (N_HID cycles, counter i=0..N_HID-1) -> OUT (N_OUT cycles, j=0..N_OUT-1) -> DONE (1 cycle) -> IDLE. DONE with start=1 goes directly to HID (back-to-back).
- Accept: start=1 in IDLE/DONE latches x_in and clears i, j, running best. start in HID/OUT is ignored; no queueing.
- Hidden neuron i: pop = popcount(~(x ^ Wh[i])) over N_IN bits. sum = 2*pop - N_IN + sext(bh[i]). h[i] = (sum >= 0). Result is written to a working hidden register.
- Output neuron j: pop = popcount(~(h ^ Wo[j])) over N_HID bits. score[j] = 2*pop - N_HID + sext(bo[j]), in SCW bits. Scores are written to a working register.
- Argmax is incremental during OUT. j=0 initialises best. A later j replaces best only if strictly greater, so ties resolve to the lowest index.
- Latency: with start accepted at edge 0, done is high in the cycle after edge N_HID+N_OUT+1. For defaults, that is 11 edges.
- In DONE, class_out, scores, and hidden_out update together with the done pulse. They are held until the next DONE or reset.
- Config writes:
  - Accepted only when state is IDLE or DONE and cfg_addr < N_HID (sel 0/1) or cfg_addr < N_OUT (sel 2/3).
  - Otherwise the write is dropped and cfg_rej pulses on the next cycle.
  - A write in the same cycle as an accepted start takes effect and is used by that run.
  - Unused upper cfg_data bits are ignored.
- Arithmetic: all sums are computed at SCW+1 bits internally, then truncated; the SCW parameter constraint guarantees no overflow.
- cfg_rej and done are never high for more than one consecutive cycle per event.

Test Plan:
1. Reset, then start with x_in=0x00 (all weights and biases 0) -> h=0xFF, scores={-8,-8}, class_out=0 (tie), done 11 edges after start, busy high edges 1..10.
2. Load Wh[all]=0xFF, bh[0]=-1, Wo[0]=0x00, Wo[1]=0xFE, x_in=0x0F -> hidden_out=0xFE, score0=-6, score1=+8, class_out=1.
3. Pulse start and cfg_we (sel=0, addr=2) mid-HID -> second start ignored, cfg_rej pulses once, Wh[2] unchanged (verified on the next run), exactly one done.
4. Assert rst at edge 5 of a run -> busy=0, no done, outputs=0, weights back to 0 (re-run of scenario 1 matches).
5. Hold start high continuously -> done every 11 edges, each run re-latching the current x_in. Toggle x_in between 0x0F and 0xF0 and check alternating results.
6. Set bh[3]=+31 and bh[4]=-32 -> h[3]=1 and h[4]=0 for every x_in across 16 random vectors. Also, cfg_addr=9 with sel=2 -> cfg_rej.
